// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and
// an auxiliary (loader/debug) requester, one fixed-latency access at a time.
module mem_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic          aux_gnt,
    output logic          aux_done,
    output logic [DW-1:0] aux_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic       OWN_CPU = 1'b0;
    localparam logic       OWN_AUX = 1'b1;
    localparam logic [1:0] LAT_M1  = 2'(RD_LAT - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic          r_last;
    logic [1:0]    r_cnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_cpu_rdata;
    logic [DW-1:0] r_aux_rdata;

    logic w_any;
    logic w_pick_aux;

    assign w_any = cpu_req | aux_req;
    // On a tie the port that was not granted last wins.
    assign w_pick_aux = aux_req & (~cpu_req | (r_last == OWN_CPU));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 2'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt   = 1'b0;
        aux_gnt   = 1'b0;
        cpu_done  = 1'b0;
        aux_done  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (r_state)
            S_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                cpu_gnt   = (r_owner == OWN_CPU);
                aux_gnt   = (r_owner == OWN_AUX);
            end
            S_DONE: begin
                cpu_done = (r_owner == OWN_CPU);
                aux_done = (r_owner == OWN_AUX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= OWN_CPU;
            r_last      <= OWN_AUX;
            r_cnt       <= 2'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_aux_rdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick_aux;
                        r_we    <= w_pick_aux ? aux_we    : cpu_we;
                        r_addr  <= w_pick_aux ? aux_addr  : cpu_addr;
                        r_wdata <= w_pick_aux ? aux_wdata : cpu_wdata;
                    end
                end
                S_ISSUE: begin
                    r_last <= r_owner;
                    r_cnt  <= LAT_M1;
                end
                S_WAIT: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else if (!r_we) begin
                        if (r_owner == OWN_AUX) r_aux_rdata <= mem_rdata;
                        else                    r_cpu_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign aux_rdata = r_aux_rdata;

endmodule
